// File: rtl/register_file_cell.sv
// -----------------------------------------------------------------------------
// register_file_cell
//
// One architectural register of the core's register file: a data word plus a
// dirty bit that marks the register as still owed a value by an outstanding
// memory load. The parent register file instantiates one cell per non-zero
// register index and feeds it already-decoded write enables.
//
// Ports:
//   clk           rising-edge clock for all state
//   sync_rst      asynchronous, active-high reset (clears data and dirty)
//   clk_en        global clock enable; when low, all state holds
//   Write_En      ALU/writeback write strobe for this cell
//   DataIn        ALU/writeback data
//   Dirty_Set     marks the register as awaiting a memory load
//   Mem_Write_En  memory-return write strobe for this cell
//   Mem_DataIn    memory-return data
//   DataOut       stored word, straight from the register
//   DirtyBitOut   stored dirty bit, straight from the register
//
// Parameters:
//   BITWIDTH        width of the stored word
//   REGADDRBITWIDTH register address width, kept for interface uniformity
//
// Optional build macro:
//   REGCELL_WRITE_GUARD_EN  when defined, an ALU write is dropped while the
//                           register is dirty and no memory return is landing
//                           in the same cycle, so a pending load is never
//                           clobbered by a younger ALU result.
//
// Data priority : memory return > ALU write > hold.
// Dirty priority: Dirty_Set > memory return (clears) > hold.
// Write_En never touches the dirty bit. There is no write-to-read bypass:
// written values become visible the cycle after the write edge.
// -----------------------------------------------------------------------------
module register_file_cell #(
    parameter int BITWIDTH        = 16,
    parameter int REGADDRBITWIDTH = 4
) (
    input  logic                clk,
    input  logic                sync_rst,
    input  logic                clk_en,
    input  logic                Write_En,
    input  logic [BITWIDTH-1:0] DataIn,
    input  logic                Dirty_Set,
    input  logic                Mem_Write_En,
    input  logic [BITWIDTH-1:0] Mem_DataIn,
    output logic [BITWIDTH-1:0] DataOut,
    output logic                DirtyBitOut
);

    logic [BITWIDTH-1:0] dataReg;
    logic                dirtyReg;
    logic [BITWIDTH-1:0] dataNext;
    logic                dirtyNext;
    logic                aluWriteOk;

    // Qualified ALU write. With the guard built in, a dirty register only
    // accepts data from the memory-return port.
`ifdef REGCELL_WRITE_GUARD_EN
    assign aluWriteOk = Write_En & ~(dirtyReg & ~Mem_Write_En);
`else
    assign aluWriteOk = Write_En;
`endif

    // Next-state selection. clk_en is folded in here so the register below
    // stays a plain flop with an asynchronous clear.
    always_comb begin
        dataNext  = dataReg;
        dirtyNext = dirtyReg;
        if (clk_en) begin
            if (Mem_Write_En) begin
                dataNext = Mem_DataIn;
            end else if (aluWriteOk) begin
                dataNext = DataIn;
            end

            // A new load issued in the same cycle as an older load returning
            // leaves the register dirty: the new load is still outstanding.
            if (Dirty_Set) begin
                dirtyNext = 1'b1;
            end else if (Mem_Write_En) begin
                dirtyNext = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge sync_rst) begin
        if (sync_rst) begin
            dataReg  <= '0;
            dirtyReg <= 1'b0;
        end else begin
            dataReg  <= dataNext;
            dirtyReg <= dirtyNext;
        end
    end

    assign DataOut     = dataReg;
    assign DirtyBitOut = dirtyReg;

    // The address width is not used by the cell's logic; this only keeps a
    // nonsensical configuration from going unnoticed in simulation.
    addrWidthSane: assert property (@(posedge clk) REGADDRBITWIDTH > 0);

endmodule

// File: tb/tb_register_file_cell.sv
module tb_register_file_cell;

  localparam int W = 16;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         sync_rst;
  logic         clk_en;
  logic         Write_En;
  logic [W-1:0] DataIn;
  logic         Dirty_Set;
  logic         Mem_Write_En;
  logic [W-1:0] Mem_DataIn;
  logic [W-1:0] DataOut;
  logic         DirtyBitOut;

  always #5 clk = ~clk;

  register_file_cell #(.BITWIDTH(W), .REGADDRBITWIDTH(4)) dut (
    .clk          (clk),
    .sync_rst     (sync_rst),
    .clk_en       (clk_en),
    .Write_En     (Write_En),
    .DataIn       (DataIn),
    .Dirty_Set    (Dirty_Set),
    .Mem_Write_En (Mem_Write_En),
    .Mem_DataIn   (Mem_DataIn),
    .DataOut      (DataOut),
    .DirtyBitOut  (DirtyBitOut)
  );

  // ---------------------------------------------------------------------------
  // Reference model: the register's architectural contents
  // ---------------------------------------------------------------------------
  logic [W-1:0] model_data;
  logic         model_dirty;

  // Apply one clock edge's worth of the register's rules to the model.
  task automatic model_edge(input logic ce, input logic we, input logic [W-1:0] din,
                            input logic ds, input logic mwe, input logic [W-1:0] mdin);
    logic alu_allowed;
    if (!ce) return;
    alu_allowed = we;
`ifdef REGCELL_WRITE_GUARD_EN
    // A register awaiting a load refuses ALU results unless the load lands now.
    if (model_dirty && !mwe) alu_allowed = 1'b0;
`endif
    if (mwe)              model_data = mdin;
    else if (alu_allowed) model_data = din;
    if (ds)       model_dirty = 1'b1;
    else if (mwe) model_dirty = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [W:0] exp_q[$];      // {dirty, data} expected after the next edge
  string      name_q[$];
  int         checks = 0;
  int         passed = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
  endtask

  // Monitor: the cell presents a new value after every rising edge, so each
  // edge consumes one queued expectation when one is outstanding.
  always @(posedge clk) begin
    logic [W:0] e;
    string      n;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      check({n, ".data"}, DataOut, e[W-1:0]);
      check({n, ".dirty"}, {{(W-1){1'b0}}, DirtyBitOut}, {{(W-1){1'b0}}, e[W]});
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Apply one cycle of stimulus at the falling edge; the outputs must not move
  // until the following rising edge.
  task automatic drive(input string name, input logic ce, input logic we, input logic [W-1:0] din,
                       input logic ds, input logic mwe, input logic [W-1:0] mdin);
    @(negedge clk);
    clk_en       = ce;
    Write_En     = we;
    DataIn       = din;
    Dirty_Set    = ds;
    Mem_Write_En = mwe;
    Mem_DataIn   = mdin;
    #1;
    check({name, ".no_bypass"}, DataOut, model_data);
    model_edge(ce, we, din, ds, mwe, mdin);
    exp_q.push_back({model_dirty, model_data});
    name_q.push_back(name);
  endtask

  task automatic idle_inputs();
    clk_en       = 1'b1;
    Write_En     = 1'b0;
    DataIn       = '0;
    Dirty_Set    = 1'b0;
    Mem_Write_En = 1'b0;
    Mem_DataIn   = '0;
  endtask

  // Assert reset between edges and confirm it clears the cell immediately.
  task automatic mid_cycle_reset(input string name);
    @(negedge clk);
    idle_inputs();
    #2;
    sync_rst = 1'b1;
    #1;
    model_data  = '0;
    model_dirty = 1'b0;
    check({name, ".data"}, DataOut, '0);
    check({name, ".dirty"}, {{(W-1){1'b0}}, DirtyBitOut}, '0);
    @(negedge clk);
    sync_rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int guard;
    idle_inputs();
    sync_rst    = 1'b1;
    model_data  = '0;
    model_dirty = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.data", DataOut, '0);
    check("reset.dirty", {{(W-1){1'b0}}, DirtyBitOut}, '0);
    @(negedge clk);
    sync_rst = 1'b0;

    // Directed cases
    drive("alu_write",        1, 1, 16'h1234, 0, 0, 16'h0000);
    drive("clk_en_low_holds", 0, 1, 16'h5678, 0, 0, 16'h0000);
    drive("dirty_set",        1, 0, 16'h0000, 1, 0, 16'h0000);
    drive("mem_return",       1, 0, 16'h0000, 0, 1, 16'hA5A5);
    drive("mem_beats_alu",    1, 1, 16'h0001, 0, 1, 16'h0002);
    drive("dirty_again",      1, 0, 16'h0000, 1, 0, 16'h0000);
    drive("set_beats_clear",  1, 0, 16'h0000, 1, 1, 16'h00FF);
    drive("alu_while_dirty",  1, 1, 16'h7777, 0, 0, 16'h0000);
    drive("dirty_set_held",   1, 0, 16'h0000, 1, 0, 16'h0000);
    drive("clk_en_low_mem",   0, 0, 16'h0000, 0, 1, 16'h4242);
    drive("mem_load_beef",    1, 0, 16'h0000, 0, 1, 16'hBEEF);
    drive("mem_while_clean",  1, 0, 16'h0000, 0, 1, 16'hBEEF);
    drive("dirty_over_beef",  1, 0, 16'h0000, 1, 0, 16'h0000);
    mid_cycle_reset("async_reset");
    drive("after_reset",      1, 1, 16'hC0DE, 0, 0, 16'h0000);

    // Randomized traffic, with occasional clock-enable drops and resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        mid_cycle_reset("rand_reset");
      end else begin
        drive("rand",
              ($urandom_range(0, 4) != 0),
              1'($urandom_range(0, 1)),
              16'($urandom),
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 2) == 0),
              16'($urandom));
      end
    end

    @(negedge clk);
    idle_inputs();
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/register_file_cell.md
Name: register_file_cell

Overview:
- Single architectural register for the core's register file: one data word plus one dirty (pending-load) bit.
- The register file instantiates one cell per non-zero register index. It feeds this cell already-decoded enables for the ALU writeback port, the memory-return writeback port, and the dirty-set strobe.
- The dirty bit marks a register whose value is still owed by an outstanding memory load. The parent uses it to stall readers and to report register sync.

Parameters:
- BITWIDTH, 16, width of the stored data word.
- REGADDRBITWIDTH, 4, register address width. Carried for interface uniformity only; no logic depends on it.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- sync_rst  input  1  reset, asynchronous, active-high. The port keeps the codebase name.
- clk_en  input  1  global clock enable; when 0, all state holds.
- Write_En  input  1  ALU/writeback write strobe, pre-decoded for this cell.
- DataIn  input  BITWIDTH  ALU/writeback data.
- Dirty_Set  input  1  marks the register as awaiting a memory load.
- Mem_Write_En  input  1  memory-return write strobe, pre-decoded for this cell.
- Mem_DataIn  input  BITWIDTH  memory-return data.
- DataOut  output  BITWIDTH  stored word, driven directly from the register.
- DirtyBitOut  output  1  current dirty bit, driven directly from the register.

Behaviour:
- Reset: sync_rst=1 asynchronously forces the data register to 0 and the dirty bit to 0, with no clock edge needed. It overrides clk_en and all strobes. After deassertion, the first qualifying edge updates state normally.
- All updates occur on the rising edge of clk, and only when clk_en=1. When clk_en=0, data and dirty hold regardless of strobes.
- Data register update, in priority order:
  - Mem_Write_En=1: data <= Mem_DataIn.
  - Otherwise Write_En=1: data <= DataIn.
  - Otherwise: hold.
  - When both strobes are high in the same cycle, the memory write wins.
- Dirty bit update, in priority order:
  - Dirty_Set=1: dirty <= 1. This takes priority over a clearing Mem_Write_En in the same cycle, because a new load has been issued.
  - Otherwise Mem_Write_En=1: dirty <= 0.
  - Otherwise: hold.
- Write_En never changes the dirty bit.
- Latency:
  - Written data appears on DataOut in the cycle after the write edge; there is no write-to-read bypass.
  - The dirty bit likewise appears on DirtyBitOut one cycle after Dirty_Set.
- Outputs are purely registered: no combinational path from any input to DataOut or DirtyBitOut.
- Dirty_Set while already dirty: stays 1. Mem_Write_En while clean: writes the data, dirty stays 0.

Optional Feature:
- Macro: REGCELL_WRITE_GUARD_EN.
- Defined: Write_En is ignored while DirtyBitOut=1 and Mem_Write_En=0, so an ALU writeback cannot clobber a register awaiting a load. Dirty-bit behaviour is unchanged.
- Not defined: Write_En writes whenever enabled, per the priority above.

Test Plan:
- Assert sync_rst mid-cycle with data=16'hBEEF, dirty=1 -> DataOut=0 and DirtyBitOut=0 immediately, before the next edge.
- Write_En=1, DataIn=16'h1234, clk_en=1 -> DataOut=16'h1234 after one edge, DirtyBitOut=0. Repeat with clk_en=0 and DataIn=16'h5678 -> DataOut stays 16'h1234.
- Dirty_Set=1 for one cycle -> DirtyBitOut=1. Then Mem_Write_En=1, Mem_DataIn=16'hA5A5 -> DataOut=16'hA5A5, DirtyBitOut=0.
- Write_En=1 (DataIn=16'h0001) together with Mem_Write_En=1 (Mem_DataIn=16'h0002) -> DataOut=16'h0002.
- Dirty=1, then Dirty_Set=1 together with Mem_Write_En=1 (Mem_DataIn=16'h00FF) -> DataOut=16'h00FF, DirtyBitOut stays 1.
- Dirty=1, Write_En=1, DataIn=16'h7777 -> DataOut=16'h7777 without the macro, DataOut unchanged with REGCELL_WRITE_GUARD_EN; DirtyBitOut stays 1 in both builds.
